// File: rtl/lap_watch_core_if.sv
// Key pulses in, time/lap status out for the lap stopwatch core.
// The tb drives keys through master; the core sits on slave.
interface lap_watch_core_if #(
    parameter int LAP_DEPTH = 8
);
    localparam int CW = $clog2(LAP_DEPTH) + 1;

    logic          key_start;
    logic          key_lap;
    logic          key_clear;
    logic          key_recall;
    logic [23:0]   time_bcd;
    logic [23:0]   disp_out;
    logic          running;
    logic          recall_mode;
    logic [CW-1:0] lap_count;
    logic          lap_full;
    logic          overflow;

    modport master (
        output key_start, key_lap, key_clear, key_recall,
        input  time_bcd, disp_out, running, recall_mode, lap_count, lap_full, overflow
    );

    modport slave (
        input  key_start, key_lap, key_clear, key_recall,
        output time_bcd, disp_out, running, recall_mode, lap_count, lap_full, overflow
    );
endinterface

// File: rtl/lap_watch_core.sv
// Stopwatch core: MM:SS.cc BCD time at 10 ms resolution, lap memory with
// recall display, run/stop/clear control FSM.
module lap_watch_core #(
    parameter int TICK_DIV  = 500000,
    parameter int LAP_DEPTH = 8
) (
    input  logic            clk_50Mhz,
    input  logic            rst,
    lap_watch_core_if.slave bus
);
    localparam int          PW    = $clog2(TICK_DIV);
    localparam int          IW    = $clog2(LAP_DEPTH);
    localparam int          CW    = IW + 1;
    localparam logic [23:0] T_MAX = 24'h595999;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP, S_RECALL} state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [23:0]   r_time;
    logic [CW-1:0] r_lap_cnt;
    logic [IW-1:0] r_idx;
    logic          r_ovf;
    logic          r_running;
    logic          r_recall;
    logic [23:0]   r_laps [LAP_DEPTH];

    logic          w_tick;
    logic          w_full;
    logic          w_lap_we;
    logic          w_clr;
    logic          w_idx_last;
    logic [23:0]   w_time_inc;

    // Digit order from LSB: cc units, cc tens, SS units, SS tens, MM units, MM tens.
    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] n;
        logic        carry;
        logic [3:0]  lim;
        n     = t;
        carry = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (carry) begin
                if (n[i*4 +: 4] >= lim) begin
                    n[i*4 +: 4] = 4'd0;
                end else begin
                    n[i*4 +: 4] = n[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return n;
    endfunction

    assign w_tick     = (r_state == S_RUN) && (r_presc == PW'(TICK_DIV - 1));
    assign w_full     = (r_lap_cnt == CW'(LAP_DEPTH));
    assign w_lap_we   = (r_state == S_RUN) && bus.key_lap && !bus.key_start && !w_full;
    assign w_clr      = bus.key_clear && (r_state == S_STOP || r_state == S_RECALL);
    assign w_idx_last = ({1'b0, r_idx} == r_lap_cnt - CW'(1));
    assign w_time_inc = bcd_inc(r_time);

    // Slot contents survive a clear; lap count alone decides what is valid.
    always_ff @(posedge clk_50Mhz) begin
        if (w_lap_we) r_laps[r_lap_cnt[IW-1:0]] <= r_time;
    end

    always_ff @(posedge clk_50Mhz or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_time    <= '0;
            r_lap_cnt <= '0;
            r_idx     <= '0;
            r_ovf     <= 1'b0;
            r_running <= 1'b0;
            r_recall  <= 1'b0;
        end else if (w_clr) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_time    <= '0;
            r_lap_cnt <= '0;
            r_idx     <= '0;
            r_ovf     <= 1'b0;
            r_running <= 1'b0;
            r_recall  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.key_start) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_presc <= w_tick ? '0 : r_presc + 1'b1;
                    if (w_tick) begin
                        r_time <= w_time_inc;
                        if (r_time == T_MAX) r_ovf <= 1'b1;
                    end
                    if (w_lap_we) r_lap_cnt <= r_lap_cnt + 1'b1;
                    if (bus.key_start) begin
                        r_state   <= S_STOP;
                        r_running <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (bus.key_start) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end else if (bus.key_recall && r_lap_cnt != '0) begin
                        r_state  <= S_RECALL;
                        r_idx    <= '0;
                        r_recall <= 1'b1;
                    end
                end
                S_RECALL: begin
                    if (bus.key_start) begin
                        r_state  <= S_STOP;
                        r_recall <= 1'b0;
                    end else if (bus.key_recall) begin
                        r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.time_bcd    = r_time;
    assign bus.disp_out    = r_recall ? r_laps[r_idx] : r_time;
    assign bus.running     = r_running;
    assign bus.recall_mode = r_recall;
    assign bus.lap_count   = r_lap_cnt;
    assign bus.lap_full    = w_full;
    assign bus.overflow    = r_ovf;
endmodule

// File: tb/tb_lap_watch_core.sv
// Directed + random bench for lap_watch_core against a centisecond/queue model.
module tb_lap_watch_core;
    localparam int TD = 4;
    localparam int LD = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_RECALL = 3;

    logic clk_50Mhz = 1'b0;
    logic rst       = 1'b0;

    lap_watch_core_if #(.LAP_DEPTH(LD)) bus ();

    lap_watch_core #(.TICK_DIV(TD), .LAP_DEPTH(LD)) dut (
        .clk_50Mhz (clk_50Mhz),
        .rst       (rst),
        .bus       (bus)
    );

    always #5 clk_50Mhz = ~clk_50Mhz;

    int tests = 0;
    int fails = 0;

    // Model: time as elapsed centiseconds, laps as a queue of centiseconds.
    int m_mode, m_cs, m_pre, m_idx;
    bit m_ovf;
    int m_laps[$];

    function automatic logic [23:0] to_bcd(input int cs);
        int mm, ss, cc;
        mm = cs / 6000;
        ss = (cs / 100) % 60;
        cc = cs % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    function automatic void m_reset();
        m_mode = M_IDLE; m_cs = 0; m_pre = 0; m_idx = 0; m_ovf = 1'b0;
        m_laps.delete();
    endfunction

    function automatic void m_step(input bit ks, input bit kl, input bit kc, input bit kr);
        bit tick;
        case (m_mode)
            M_IDLE: if (ks) m_mode = M_RUN;
            M_RUN: begin
                tick = (m_pre == TD - 1);
                if (kl && !ks && m_laps.size() < LD) m_laps.push_back(m_cs);
                m_pre = tick ? 0 : m_pre + 1;
                if (tick) begin
                    if (m_cs == 359999) begin m_cs = 0; m_ovf = 1'b1; end
                    else m_cs = m_cs + 1;
                end
                if (ks) m_mode = M_STOP;
            end
            M_STOP: begin
                if (kc) m_reset();
                else if (ks) m_mode = M_RUN;
                else if (kr && m_laps.size() > 0) begin m_mode = M_RECALL; m_idx = 0; end
            end
            default: begin
                if (kc) m_reset();
                else if (ks) m_mode = M_STOP;
                else if (kr) m_idx = (m_idx + 1) % m_laps.size();
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [23:0] disp_exp;
        disp_exp = (m_mode == M_RECALL) ? to_bcd(m_laps[m_idx]) : to_bcd(m_cs);
        chk({tag, ".time"},    bus.time_bcd,    to_bcd(m_cs));
        chk({tag, ".disp"},    bus.disp_out,    disp_exp);
        chk({tag, ".running"}, bus.running,     m_mode == M_RUN);
        chk({tag, ".recall"},  bus.recall_mode, m_mode == M_RECALL);
        chk({tag, ".lapcnt"},  bus.lap_count,   m_laps.size());
        chk({tag, ".lapfull"}, bus.lap_full,    m_laps.size() == LD);
        chk({tag, ".ovf"},     bus.overflow,    m_ovf);
    endtask

    task automatic step(input bit ks, input bit kl, input bit kc, input bit kr);
        bus.key_start = ks; bus.key_lap = kl; bus.key_clear = kc; bus.key_recall = kr;
        @(posedge clk_50Mhz);
        m_step(ks, kl, kc, kr);
        #1;
        bus.key_start = 1'b0; bus.key_lap = 1'b0; bus.key_clear = 1'b0; bus.key_recall = 1'b0;
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            check_all(tag);
        end
    endtask

    initial begin
        int cs0, n;
        logic [23:0] lap_tick_exp;
        bus.key_start = 1'b0; bus.key_lap = 1'b0; bus.key_clear = 1'b0; bus.key_recall = 1'b0;
        m_reset();
        #12;
        check_all("reset");
        @(negedge clk_50Mhz) rst = 1'b1;

        idle(3, "idle");
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check_all("idle_keys");

        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("start");
        idle(400, "run400");
        chk("t400.time", bus.time_bcd, 24'h000100);
        chk("t400.running", bus.running, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(100, "hold");
        chk("hold.time", bus.time_bcd, 24'h000100);
        chk("hold.running", bus.running, 1'b0);

        // Stop two prescaler counts past a tick, then resume.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (m_pre != 1 && n < 8) begin step(1'b0, 1'b0, 1'b0, 1'b0); n++; end
        chk("partial.bound", n < 8, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        cs0 = m_cs;
        idle(5, "partial.stop");
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("partial.r1", bus.time_bcd, to_bcd(cs0));
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("partial.r2", bus.time_bcd, to_bcd(cs0 + 1));
        check_all("partial");

        // Jump close to 59:59.99 so the wrap is reached in a few hundred cycles.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        force dut.r_time = 24'h595890;
        #1 release dut.r_time;
        m_cs = 359890;
        check_all("preload");
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(500, "wrap");
        chk("wrap.ovf", bus.overflow, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check_all("clear");
        chk("clear.ovf", bus.overflow, 1'b0);
        chk("clear.time", bus.time_bcd, 24'h000000);

        // Five laps; the third lands on a tick edge.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        lap_tick_exp = '0;
        for (int k = 0; k < 5; k++) begin
            idle(3 + 5 * k, "lap.gap");
            if (k == 2) begin
                n = 0;
                while (m_pre != TD - 1 && n < 8) begin step(1'b0, 1'b0, 1'b0, 1'b0); n++; end
                lap_tick_exp = to_bcd(m_cs);
            end
            step(1'b0, 1'b1, 1'b0, 1'b0);
            check_all("lap");
        end
        chk("lap.count", bus.lap_count, 3'd4);
        chk("lap.full", bus.lap_full, 1'b1);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            check_all("recall");
            chk("recall.mode", bus.recall_mode, 1'b1);
            if (k == 2) chk("recall.tick_lap", bus.disp_out, lap_tick_exp);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check_all("recall_exit");
        chk("recall_exit.disp", bus.disp_out, bus.time_bcd);

        step(1'b1, 1'b0, 1'b1, 1'b0);
        check_all("clr_start");
        chk("clr_start.running", bus.running, 1'b0);
        chk("clr_start.lapcnt", bus.lap_count, 3'd0);

        repeat (3000) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0);
            check_all("rand");
        end

        // Asynchronous reset in the middle of a RUN cycle.
        if (m_mode != M_RUN) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            if (m_mode != M_RUN) step(1'b1, 1'b0, 1'b0, 1'b0);
        end
        idle(7, "pre_rst");
        #1 rst = 1'b0;
        #1;
        m_reset();
        check_all("rst_async");
        chk("rst_async.time", bus.time_bcd, 24'h000000);
        @(negedge clk_50Mhz) rst = 1'b1;
        idle(3, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lap_watch_core.md
LAP_WATCH_CORE -- requirements
Module: lap_watch_core

Interface
REQ-001 Parameter TICK_DIV, default 500000, number of clk_50Mhz cycles per 10 ms tick (legal range 2 or greater).
REQ-002 Parameter LAP_DEPTH, default 8, number of lap slots (power of 2, legal range 2 to 64).
REQ-003 Port clk_50Mhz, input, 1 bit, the single clock; all state is on its rising edge.
REQ-004 Port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 Port key_start, input, 1 bit, single-cycle pulse that toggles run/stop.
REQ-006 Port key_lap, input, 1 bit, single-cycle pulse that captures the current time into the next lap slot.
REQ-007 Port key_clear, input, 1 bit, single-cycle pulse that zeroes the time and empties the lap memory.
REQ-008 Port key_recall, input, 1 bit, single-cycle pulse that enters or steps lap-recall display.
REQ-009 Port time_bcd, output, 24 bits, live time as MM:SS:cc in BCD, digits [23:20] down to [3:0].
REQ-010 Port disp_out, output, 24 bits, display word: time_bcd, or the recalled lap while in RECALL.
REQ-011 Port running, output, 1 bit, high only in RUN.
REQ-012 Port recall_mode, output, 1 bit, high only in RECALL.
REQ-013 Port lap_count, output, $clog2(LAP_DEPTH)+1 bits, number of stored laps.
REQ-014 Port lap_full, output, 1 bit, high when lap_count == LAP_DEPTH.
REQ-015 Port overflow, output, 1 bit, sticky flag set on time wrap.

Function
REQ-016 FSM states: IDLE (time zero, stopped), RUN, STOP (paused), RECALL; state is encoded in a registered state variable.
REQ-017 Transitions from IDLE: key_start goes to RUN; all other keys are ignored.
REQ-018 Transitions from RUN: key_start goes to STOP; key_lap stores the lap and stays in RUN; key_clear and key_recall are ignored.
REQ-019 Transitions from STOP: key_start goes to RUN; key_clear goes to IDLE; key_recall goes to RECALL with recall index 0, but only if lap_count > 0, otherwise it is ignored.
REQ-020 Transitions from RECALL: key_recall advances the index, wrapping from lap_count-1 to 0; key_start returns to STOP; key_clear goes to IDLE.
REQ-021 Simultaneous keys use priority key_clear > key_start > key_lap > key_recall; only the highest-priority legal key acts in a given cycle.
REQ-022 The prescaler counts 0 to TICK_DIV-1 only in RUN and emits a one-cycle tick at TICK_DIV-1.
REQ-023 The prescaler holds its value in STOP and RECALL, so a resume continues the partial interval.
REQ-024 The prescaler is zeroed on entry to IDLE.
REQ-025 On each tick, time_bcd increments as a BCD cascade: cc 00-99, then SS 00-59, then MM 00-59; no digit ever holds a value above 9.
REQ-026 A tick at 59:59.99 wraps time_bcd to 00:00.00 and sets overflow; overflow clears only on key_clear or reset.
REQ-027 key_lap in RUN with lap_count < LAP_DEPTH writes the value time_bcd holds before the edge into slot lap_count, then increments lap_count; a same-cycle tick does not alter the captured value.
REQ-028 key_lap with lap_full high is dropped: no write and no count change.
REQ-029 key_clear zeroes time_bcd, lap_count, overflow and the prescaler; lap slot contents need not be cleared.
REQ-030 disp_out is a combinational mux of registered values: lap slot[recall index] in RECALL, time_bcd otherwise; time and state outputs reflect a change on the edge after the key pulse.
REQ-031 time_bcd never changes in STOP, RECALL or IDLE.

Reset
REQ-032 While rst is low, asynchronously: state = IDLE; time_bcd = disp_out = 24'h000000; prescaler = 0; running = recall_mode = overflow = lap_full = 0; lap_count = 0; recall index = 0.
REQ-033 Reset asserted mid-RUN or mid-RECALL takes effect immediately, without waiting for a clock edge.
REQ-034 After rst deasserts, the block waits in IDLE for key_start.

Verification (TICK_DIV=4, LAP_DEPTH=4)
REQ-035 key_start then 400 cycles: running=1, time_bcd=24'h000100; key_start again: running=0, value holds for 100 cycles.
REQ-036 Stop at 2 cycles past a tick, resume: the next increment occurs 2 cycles after resume.
REQ-037 Preload time to 59:59.99 via ticks, one more tick: time_bcd=24'h000000, overflow=1; key_clear from STOP: overflow=0, state IDLE.
REQ-038 Five key_lap pulses at distinct times in RUN: lap_count=4, lap_full=1, fifth dropped; key_lap on a tick cycle captures the pre-tick value.
REQ-039 STOP, then key_recall x5: disp_out shows slots 0,1,2,3,0 and recall_mode=1; key_start returns to STOP, disp_out=time_bcd.
REQ-040 key_clear and key_start in the same cycle from STOP: goes to IDLE, all zero; rst low mid-RUN: all outputs zero before the next edge.
